spi_fwm_txf_ctrl: RTL

SPI_FWM_TXF_CTRL -- requirements
Module: spi_fwm_txf_ctrl

---
 rtl/spi_fwm_txf_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_fwm_txf_ctrl.sv
// SPI TX-FIFO fill controller: reads words from an SRAM circular buffer between
// base and limit and pushes them a byte at a time into the TX byte FIFO.
module spi_fwm_txf_ctrl #(
    parameter int unsigned FifoDw = 8,
    parameter int unsigned SramAw = 11,
    parameter int unsigned SramDw = 32,
    localparam int unsigned NumBytes = SramDw / FifoDw,
    localparam int unsigned SDW = $clog2(NumBytes),
    localparam int unsigned PtrW = SramAw + SDW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [SramAw-1:0] base_index_i,
    input  logic [SramAw-1:0] limit_index_i,

    input  logic [PtrW-1:0]   wptr,
    output logic [PtrW-1:0]   rptr,
    output logic [PtrW-1:0]   depth,
    output logic              empty,

    output logic              fifo_valid,
    input  logic              fifo_ready,
    output logic [FifoDw-1:0] fifo_wdata,

    output logic              sram_req,
    output logic              sram_write,
    output logic [SramAw-1:0] sram_addr,
    output logic [SramDw-1:0] sram_wdata,
    input  logic              sram_gnt,
    input  logic              sram_rvalid,
    input  logic [SramDw-1:0] sram_rdata,
    input  logic [1:0]        sram_error
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWait  = 3'd2,
        StPush  = 3'd3,
        StRetry = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [PtrW-1:0]   wptr_snap_q, wptr_snap_d;
    logic [SramDw-1:0] wbuf_q, wbuf_d;

    logic [SramAw-1:0] sramf_limit;
    logic              r_phase;
    logic [SramAw-1:0] r_word;
    logic [SDW-1:0]    r_lane;
    logic              last_lane;
    logic [PtrW-1:0]   rptr_inc;
    logic [PtrW-1:0]   w_low, r_low, lim_low;

    assign sramf_limit = limit_index_i - base_index_i;
    assign r_phase     = rptr_q[PtrW-1];
    assign r_word      = rptr_q[PtrW-2:SDW];
    assign r_lane      = rptr_q[SDW-1:0];
    assign last_lane   = (r_lane == SDW'(NumBytes - 1));

    // Byte advance; leaving the last lane of the limit word wraps to base and flips phase.
    always_comb begin
        if (!last_lane) begin
            rptr_inc = rptr_q + PtrW'(1);
        end else if (r_word == sramf_limit) begin
            rptr_inc = {~r_phase, (PtrW-1)'(0)};
        end else begin
            rptr_inc = {r_phase, r_word + SramAw'(1), SDW'(0)};
        end
    end

    // Unread byte count; differing phases mean the writer has wrapped past the limit.
    always_comb begin
        w_low   = {1'b0, wptr[PtrW-2:0]};
        r_low   = {1'b0, rptr_q[PtrW-2:0]};
        lim_low = {1'b0, sramf_limit, {SDW{1'b1}}};
        if (wptr[PtrW-1] == r_phase) begin
            depth = w_low - r_low;
        end else begin
            depth = w_low + (lim_low - r_low) + PtrW'(1);
        end
    end

    assign empty = (rptr_q == wptr);

    always_comb begin
        state_d     = state_q;
        rptr_d      = rptr_q;
        wptr_snap_d = wptr_snap_q;
        wbuf_d      = wbuf_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d     = StRead;
                    wptr_snap_d = wptr;
                end
            end
            StRead: begin
                if (sram_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sram_rvalid) begin
                    if (sram_error == 2'b00) begin
                        wbuf_d  = sram_rdata;
                        state_d = StPush;
                    end else begin
                        state_d = StRetry;
                    end
                end
            end
            StPush: begin
                // Stop at the word boundary or the snapshot; later bytes re-read the word.
                if (fifo_ready) begin
                    rptr_d = rptr_inc;
                    if (last_lane || (rptr_inc == wptr_snap_q)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRetry: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rptr_q      <= '0;
            wptr_snap_q <= '0;
            wbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            wptr_snap_q <= wptr_snap_d;
            wbuf_q      <= wbuf_d;
        end
    end

    assign rptr       = rptr_q;
    assign sram_req   = (state_q == StRead);
    assign sram_addr  = base_index_i + r_word;
    assign sram_write = 1'b0;
    assign sram_wdata = '0;
    assign fifo_valid = (state_q == StPush);
    assign fifo_wdata = wbuf_q[r_lane*FifoDw +: FifoDw];

endmodule
